// File: rtl/match_collector_if.sv
// Bundle between match_collector and its neighbours: the search engine
// handshake plus the FIFO drain port.
interface match_collector_if #(
  parameter int AW = 8
);
  logic          srch_reset;
  logic          srch_activate;
  logic          srch_done;
  logic [AW-1:0] srch_found;
  logic          rd_en;
  logic [AW-1:0] rd_data;
  logic          empty;

  modport master (
    output srch_reset, srch_activate, rd_data, empty,
    input  srch_done, srch_found, rd_en
  );

  modport slave (
    input  srch_reset, srch_activate, rd_data, empty,
    output srch_done, srch_found, rd_en
  );
endinterface

// File: rtl/match_collector.sv
// Scans region [b, b+bl) with the search engine and stores each match in a FWFT FIFO.
// Optional watchdog on the done wait: define MATCH_COLLECTOR_TIMEOUT_EN.
module match_collector #(
  parameter int            DEPTH          = 16,
  parameter int            AW             = 8,
  parameter logic [AW-1:0] NOT_FOUND      = {AW{1'b1}},
  parameter int            TIMEOUT_CYCLES = 1024
) (
  input  logic          CLK100MHZ,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] b,
  input  logic [AW-1:0] bl,
  output logic          busy,
  output logic [AW:0]   match_count,
  output logic          overflow,
  output logic          scan_done,
  match_collector_if.master bus
`ifdef MATCH_COLLECTOR_TIMEOUT_EN
  , output logic        timeout
`endif
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, SRST, REQ, WAIT, EVAL, FIN} state_t;

  state_t        state_q, state_d;
  logic [AW:0]   end_q, end_d;
  logic [AW-1:0] found_q, found_d;
  logic          done_prev_q, done_prev_d;
  logic          busy_q, busy_d;
  logic          srch_reset_q, srch_reset_d;
  logic          srch_act_q, srch_act_d;
  logic          scan_done_q, scan_done_d;
  logic [AW:0]   match_count_q, match_count_d;
  logic          overflow_q, overflow_d;
  logic [PW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] rd_data_q, rd_data_d;
  logic [AW-1:0] mem_q [DEPTH];
  logic          push, pop, flush, empty, full, done_edge;
`ifdef MATCH_COLLECTOR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] wd_q, wd_d;
  logic          timeout_q, timeout_d;
`endif

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign done_edge = bus.srch_done & ~done_prev_q;
  assign pop       = bus.rd_en & ~empty;

  always_comb begin
    state_d       = state_q;
    end_d         = end_q;
    found_d       = found_q;
    done_prev_d   = bus.srch_done;
    busy_d        = busy_q;
    srch_reset_d  = 1'b0;
    srch_act_d    = 1'b0;
    scan_done_d   = 1'b0;
    match_count_d = match_count_q;
    overflow_d    = overflow_q;
    push          = 1'b0;
    flush         = 1'b0;
`ifdef MATCH_COLLECTOR_TIMEOUT_EN
    wd_d          = wd_q;
    timeout_d     = timeout_q;
`endif
    unique case (state_q)
      IDLE: if (start) begin
        end_d         = {1'b0, b} + {1'b0, bl};
        match_count_d = '0;
        overflow_d    = 1'b0;
        flush         = 1'b1;
        busy_d        = 1'b1;
        srch_reset_d  = 1'b1;
        state_d       = SRST;
`ifdef MATCH_COLLECTOR_TIMEOUT_EN
        timeout_d     = 1'b0;
`endif
      end
      SRST: begin
        srch_act_d = 1'b1;
        state_d    = REQ;
      end
      REQ: begin
        state_d = WAIT;
`ifdef MATCH_COLLECTOR_TIMEOUT_EN
        wd_d    = '0;
`endif
      end
      WAIT: begin
        if (done_edge) begin
          found_d = bus.srch_found;
          state_d = EVAL;
        end
`ifdef MATCH_COLLECTOR_TIMEOUT_EN
        else if (wd_q == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout_d   = 1'b1;
          scan_done_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = FIN;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      EVAL: begin
        if (found_q == NOT_FOUND || {1'b0, found_q} >= end_q) begin
          scan_done_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = FIN;
        end else if (!full) begin
          push       = 1'b1;
          srch_act_d = 1'b1;
          state_d    = REQ;
          if (match_count_q != (AW+1)'(DEPTH))
            match_count_d = match_count_q + 1'b1;
        end else begin
          overflow_d  = 1'b1;
          scan_done_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Next head is the word being written this cycle when the FIFO was drained to it.
    rd_ptr_d  = flush ? '0 : rd_ptr_q + (PW+1)'(pop);
    wr_ptr_d  = flush ? '0 : wr_ptr_q + (PW+1)'(push);
    rd_data_d = rd_data_q;
    if (!flush && rd_ptr_d != wr_ptr_d) begin
      if (push && rd_ptr_d == wr_ptr_q) rd_data_d = found_q;
      else                              rd_data_d = mem_q[rd_ptr_d[PW-1:0]];
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_q       <= IDLE;
      end_q         <= '0;
      found_q       <= '0;
      done_prev_q   <= 1'b0;
      busy_q        <= 1'b0;
      srch_reset_q  <= 1'b0;
      srch_act_q    <= 1'b0;
      scan_done_q   <= 1'b0;
      match_count_q <= '0;
      overflow_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      rd_data_q     <= '0;
`ifdef MATCH_COLLECTOR_TIMEOUT_EN
      wd_q          <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      end_q         <= end_d;
      found_q       <= found_d;
      done_prev_q   <= done_prev_d;
      busy_q        <= busy_d;
      srch_reset_q  <= srch_reset_d;
      srch_act_q    <= srch_act_d;
      scan_done_q   <= scan_done_d;
      match_count_q <= match_count_d;
      overflow_q    <= overflow_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      rd_data_q     <= rd_data_d;
`ifdef MATCH_COLLECTOR_TIMEOUT_EN
      wd_q          <= wd_d;
      timeout_q     <= timeout_d;
`endif
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (push) mem_q[wr_ptr_q[PW-1:0]] <= found_q;
  end

  assign busy              = busy_q;
  assign match_count       = match_count_q;
  assign overflow          = overflow_q;
  assign scan_done         = scan_done_q;
  assign bus.srch_reset    = srch_reset_q;
  assign bus.srch_activate = srch_act_q;
  assign bus.rd_data       = rd_data_q;
  assign bus.empty         = empty;
`ifdef MATCH_COLLECTOR_TIMEOUT_EN
  assign timeout           = timeout_q;
`endif
endmodule

// File: tb/tb_match_collector.sv
// Randomized bench for match_collector: search engine model, monitor and scan-level reference.
module tb_match_collector;
  localparam int AW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [AW-1:0] b, bl;
  logic          busy, overflow, scan_done;
  logic [AW:0]   match_count;
`ifdef MATCH_COLLECTOR_TIMEOUT_EN
  logic          timeout;
`endif

  match_collector_if #(.AW(AW)) bus ();

  always #5 clk = ~clk;

  match_collector #(
    .DEPTH(DEPTH),
    .AW(AW),
    .NOT_FOUND(8'hFF)
`ifdef MATCH_COLLECTOR_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .CLK100MHZ(clk),
    .reset(reset),
    .start(start),
    .b(b),
    .bl(bl),
    .busy(busy),
    .match_count(match_count),
    .overflow(overflow),
    .scan_done(scan_done),
    .bus(bus)
`ifdef MATCH_COLLECTOR_TIMEOUT_EN
    , .timeout(timeout)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // Search engine model: each activate drops done, then reports the next queued response.
  logic [7:0] resp_q[$];
  bit         hang = 1'b0;
  initial begin
    bus.srch_done  = 1'b0;
    bus.srch_found = '0;
    forever begin
      @(negedge clk);
      if (bus.srch_activate) begin
        bus.srch_done = 1'b0;
        if (!hang) begin
          repeat ($urandom_range(1, 4)) @(negedge clk);
          bus.srch_found = (resp_q.size() > 0) ? resp_q.pop_front() : 8'hFF;
          bus.srch_done  = 1'b1;
        end
      end
    end
  end

  int         cyc = 0, n_act = 0, n_srst = 0, n_done = 0;
  int         start_cyc = 0, srst_cyc = 0, act_cyc = 0, done_cyc = 0;
  logic [7:0] pops[$];
  always @(negedge clk) begin
    cyc++;
    if (start && !busy) start_cyc = cyc;
    if (bus.srch_reset) begin n_srst++; srst_cyc = cyc; end
    if (bus.srch_activate) begin n_act++; act_cyc = cyc; end
    if (scan_done) begin n_done++; done_cyc = cyc; end
    if (bus.rd_en && !bus.empty) pops.push_back(bus.rd_data);
  end

  // Scan-level reference: walk the planned responses against the region rules.
  logic [7:0] plan[$];
  logic [7:0] exp_store[$];
  int         exp_cnt, exp_acts;
  bit         exp_ovf;
  function automatic void ref_model(input int bb, input int bll, input bit draining);
    int e = bb + bll;
    int stored = 0;
    exp_store.delete();
    exp_cnt = 0; exp_acts = 0; exp_ovf = 1'b0;
    for (int i = 0; ; i++) begin
      int r = (i < plan.size()) ? int'(plan[i]) : 255;
      exp_acts++;
      if (r == 255 || r >= e) break;
      if (draining || stored < DEPTH) begin
        exp_store.push_back(8'(r));
        stored++;
      end else begin
        exp_ovf = 1'b1;
        break;
      end
    end
    exp_cnt = (stored > DEPTH) ? DEPTH : stored;
  endfunction

  function automatic bit same_list(input logic [7:0] x[$], input logic [7:0] y[$]);
    if (x.size() != y.size()) return 1'b0;
    foreach (x[i]) if (x[i] !== y[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic pulse_start(input logic [7:0] bb, input logic [7:0] bll);
    @(posedge clk); #1;
    b = bb; bl = bll; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_scan(input logic [7:0] bb, input logic [7:0] bll, input bit hold_rd,
                          input bit extra_start);
    int k;
    resp_q = plan;
    n_act = 0; n_srst = 0; n_done = 0;
    pops.delete();
    bus.rd_en = hold_rd;
    pulse_start(bb, bll);
    if (extra_start) begin
      repeat (3) @(posedge clk);
      #1;
      pulse_start(8'd0, 8'd255);
    end
    for (k = 0; k < 2000 && n_done == 0; k++) begin @(posedge clk); #1; end
    n_cmp++;
    if (n_done == 0) begin
      n_err++;
      $display("FAIL scan_wait: scan_done not seen after %0d cycles (required within 2000)", k);
    end
    repeat (3) @(posedge clk);
    #1;
    bus.rd_en = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 64; k++) begin
      @(posedge clk); #1;
      bus.rd_en = !bus.empty;
      if (bus.empty) break;
    end
    bus.rd_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; b = '0; bl = '0; bus.rd_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, bus.srch_reset, bus.srch_activate, bus.rd_data, bus.empty, match_count, overflow, scan_done}
        !== {3'b000, 8'h00, 1'b1, 9'h000, 2'b00}) begin
      n_err++;
      $display("FAIL reset_values: got busy=%b srst=%b act=%b rd=%h empty=%b cnt=%0d ovf=%b done=%b, required 0 0 0 00 1 0 0 0",
               busy, bus.srch_reset, bus.srch_activate, bus.rd_data, bus.empty, match_count, overflow, scan_done);
    end
    reset = 1'b0;
  endtask

  task automatic test_scan(input string name, input logic [7:0] bb, input logic [7:0] bll,
                           input bit hold_rd, input bit extra_start);
    ref_model(bb, bll, hold_rd);
    run_scan(bb, bll, hold_rd, extra_start);
    n_cmp++;
    if (srst_cyc != start_cyc + 1 || n_srst != 1) begin
      n_err++;
      $display("FAIL %s srst: %0d pulses at +%0d, required 1 pulse at +1", name, n_srst, srst_cyc - start_cyc);
    end
    n_cmp++;
    if (n_act != exp_acts) begin
      n_err++;
      $display("FAIL %s activates: got %0d required %0d", name, n_act, exp_acts);
    end
    n_cmp++;
    if (n_done != 1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s done_busy: scan_done x%0d busy=%b, required x1 busy=0", name, n_done, busy);
    end
    n_cmp++;
    if (match_count !== 9'(exp_cnt) || overflow !== exp_ovf) begin
      n_err++;
      $display("FAIL %s count_ovf: got cnt=%0d ovf=%b required cnt=%0d ovf=%b",
               name, match_count, overflow, exp_cnt, exp_ovf);
    end
    if (!hold_rd) drain();
    n_cmp++;
    if (!same_list(pops, exp_store) || bus.empty !== 1'b1) begin
      n_err++;
      $display("FAIL %s fifo: got %0d values %p empty=%b, required %0d values %p empty=1",
               name, pops.size(), pops, bus.empty, exp_store.size(), exp_store);
    end
  endtask

  task automatic test_basic();
    plan = '{8'd150, 8'd160, 8'hFF};
    test_scan("basic", 8'd145, 8'd30, 1'b0, 1'b0);
  endtask

  task automatic test_region_bound();
    plan = '{8'd170, 8'd175};
    test_scan("region", 8'd145, 8'd30, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    plan = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60};
    test_scan("overflow", 8'd0, 8'd100, 1'b0, 1'b0);
  endtask

  task automatic test_concurrent();
    plan.delete();
    for (int i = 0; i < 10; i++) plan.push_back(8'($urandom_range(0, 199)));
    test_scan("concurrent", 8'd0, 8'd200, 1'b1, 1'b0);
  endtask

  task automatic test_start_busy();
    plan = '{8'd100, 8'd110, 8'd120};
    test_scan("start_busy", 8'd90, 8'd15, 1'b0, 1'b1);
  endtask

  task automatic test_bl_zero();
    plan = '{8'd50, 8'd51};
    test_scan("bl_zero", 8'd50, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap_end();
    plan = '{8'd250, 8'd254, 8'd10, 8'd255};
    test_scan("wrap_end", 8'd200, 8'd100, 1'b0, 1'b0);
  endtask

  task automatic test_reset_in_wait();
    hang = 1'b1;
    n_done = 0;
    pulse_start(8'd10, 8'd20);
    repeat (12) @(posedge clk);
    #1;
`ifndef MATCH_COLLECTOR_TIMEOUT_EN
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL hang_busy: busy=%b while waiting for done, required 1", busy);
    end
`endif
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_cmp++;
    if ({busy, bus.srch_reset, bus.srch_activate, bus.rd_data, bus.empty, match_count, overflow, scan_done}
        !== {3'b000, 8'h00, 1'b1, 9'h000, 2'b00}) begin
      n_err++;
      $display("FAIL reset_wait: got busy=%b srst=%b act=%b rd=%h empty=%b cnt=%0d ovf=%b done=%b, required 0 0 0 00 1 0 0 0",
               busy, bus.srch_reset, bus.srch_activate, bus.rd_data, bus.empty, match_count, overflow, scan_done);
    end
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (n_done != 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_abort: scan_done x%0d busy=%b after abort, required x0 busy=0", n_done, busy);
    end
    hang = 1'b0;
  endtask

`ifdef MATCH_COLLECTOR_TIMEOUT_EN
  task automatic test_timeout();
    int k;
    hang = 1'b1;
    n_done = 0;
    pulse_start(8'd0, 8'd50);
    for (k = 0; k < 200 && n_done == 0; k++) begin @(posedge clk); #1; end
    n_cmp++;
    if (timeout !== 1'b1 || n_done != 1 || done_cyc - act_cyc < 16 || done_cyc - act_cyc > 18) begin
      n_err++;
      $display("FAIL timeout: timeout=%b done x%0d at +%0d, required timeout=1 done x1 at +17",
               timeout, n_done, done_cyc - act_cyc);
    end
    hang = 1'b0;
  endtask
`endif

  task automatic test_random();
    for (int t = 0; t < 25; t++) begin
      logic [7:0] rb, rbl;
      int         n;
      rb  = 8'($urandom);
      rbl = 8'($urandom);
      n   = $urandom_range(0, 7);
      plan.delete();
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) != 0) plan.push_back(8'(int'(rb) + $urandom_range(0, int'(rbl))));
        else                           plan.push_back(8'($urandom));
      end
      test_scan("random", rb, rbl, 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_region_bound();
    test_overflow();
    test_concurrent();
    test_start_busy();
    test_bl_zero();
    test_wrap_end();
    test_reset_in_wait();
`ifdef MATCH_COLLECTOR_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
